mips_cpu_muldiv: RTL and testbench

MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

---
 rtl/mips_cpu_muldiv.sv | 99 +++++++++
 tb/tb_mips_cpu_muldiv.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative HI/LO unit, shift-add multiply and restoring divide on magnitudes,
// with sign fix-up in a final cycle before HI/LO are written.
module mips_cpu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic div_r, an_r, bn_r;
    logic [WIDTH-1:0] ma_r, mb_r;
    logic [2*WIDTH-1:0] acc;
    logic accept, sgn, an, bn;
    logic [WIDTH-1:0] ma, mb;
    logic [WIDTH:0] msum, dt, dd;
    logic [2*WIDTH-1:0] step, prod;

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    always_comb begin
        accept = state == IDLE && start && !op[2];
        sgn = !op[0];
        an = sgn && a[WIDTH-1];
        bn = sgn && b[WIDTH-1];
        ma = an ? -a : a;
        mb = bn ? -b : b;
        msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma_r} : '0);
        dt = acc[2*WIDTH-1:WIDTH-1];
        dd = dt - {1'b0, mb_r};
        step = !div_r ? {msum, acc[WIDTH-1:1]} :
               dd[WIDTH] ? {dt[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
               {dd[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod = (an_r ^ bn_r) ? -acc : acc;
        busy = state != IDLE;
        state_next = accept ? RUN :
                     (state == RUN && cnt == CW'(WIDTH - 1)) ? FIX :
                     state == FIX ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else if (clk_enable)
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
            done <= 1'b0;
            cnt <= '0;
            acc <= '0;
            ma_r <= '0;
            mb_r <= '0;
            div_r <= 1'b0;
            an_r <= 1'b0;
            bn_r <= 1'b0;
        end else if (clk_enable) begin
            done <= state == FIX;
            if (accept) begin
                div_r <= op[1];
                an_r <= an;
                bn_r <= bn;
                ma_r <= ma;
                mb_r <= mb;
                cnt <= '0;
                acc <= {{WIDTH{1'b0}}, op[1] ? ma : mb};
            end else if (state == IDLE && start && op == 3'd4) begin
                hi <= a;
            end else if (state == IDLE && start && op == 3'd5) begin
                lo <= a;
            end else if (state == RUN) begin
                acc <= step;
                cnt <= cnt + 1'b1;
            end else if (state == FIX) begin
                // a zero divisor leaves remainder = |a|, so the dividend-sign fix-up restores hi = a
                hi <= !div_r ? prod[2*WIDTH-1:WIDTH] :
                      an_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                lo <= !div_r ? prod[WIDTH-1:0] :
                      mb_r == '0 ? '1 :
                      (an_r ^ bn_r) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv: arithmetic-level reference model checked every cycle, plus literal
// expectations for the hand-worked vectors, latency, stall and abort behaviour.
module tb_mips_cpu_muldiv;
    localparam int W = 32;

    logic clk = 1'b0, reset = 1'b1, clk_enable = 1'b1, start = 1'b0;
    logic [2:0] op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic [W-1:0] hi, lo;
    logic busy, done;

    int tests = 0, fails = 0;

    mips_cpu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        if (o == 3'd0) return 64'(sx * sy);
        if (o == 3'd1) return ux * uy;
        if (y == 32'b0) return {x, 32'hFFFFFFFF};
        if (o == 3'd3) return {x % y, x / y};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // model: an accepted op completes after WIDTH+1 further enabled edges
    logic [W-1:0] m_hi, m_lo;
    logic m_done;
    int rem;
    logic [63:0] pend;
    bit armed = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0;
            m_lo = '0;
            m_done = 1'b0;
            rem = 0;
            armed = 1'b1;
        end else if (clk_enable) begin
            m_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    {m_hi, m_lo} = pend;
                    m_done = 1'b1;
                end
            end else if (start && op < 3'd4) begin
                pend = calc(op, a, b);
                rem = W + 1;
            end else if (start && op == 3'd4) begin
                m_hi = a;
            end else if (start && op == 3'd5) begin
                m_lo = a;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
            chk("busy", 64'(busy), 64'(rem > 0));
            chk("done", 64'(done), 64'(m_done));
        end
    end

    task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int cyc);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    logic [31:0] vals [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h12345678};

    initial begin
        int cyc, pulses;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_hi", 64'(hi), 64'h0);
        chk("reset_lo", 64'(lo), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);

        run(3'd0, 32'hFFFFFFFF, 32'h2, cyc);
        chk("mult_latency", 64'(cyc), 64'd34);
        chk("mult_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
        run(3'd1, 32'hFFFFFFFF, 32'h2, cyc);
        chk("multu_b2b_latency", 64'(cyc), 64'd34);
        chk("multu_res", {hi, lo}, 64'h00000001_FFFFFFFE);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'h0);

        run(3'd2, 32'hFFFFFFF9, 32'h2, cyc);
        chk("div_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run(3'd3, 32'd100, 32'd7, cyc);
        chk("divu_res", {hi, lo}, 64'h00000002_0000000E);
        run(3'd3, 32'h12345678, 32'h0, cyc);
        chk("divu_zero_latency", 64'(cyc), 64'd34);
        chk("divu_zero_res", {hi, lo}, 64'h12345678_FFFFFFFF);
        run(3'd2, 32'hFFFFFFF0, 32'h0, cyc);
        chk("div_zero_res", {hi, lo}, 64'hFFFFFFF0_FFFFFFFF);
        run(3'd2, 32'h80000000, 32'hFFFFFFFF, cyc);
        chk("div_ovf_res", {hi, lo}, 64'h00000000_80000000);

        // MTHI issued while busy must be dropped
        op = 3'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        op = 3'd4; a = 32'hDEADBEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("busy_ignore_res", {hi, lo}, 64'hFFFFFFFE_00000001);
        @(negedge clk);
        op = 3'd5; a = 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h1);
        chk("mtlo_hi", 64'(hi), 64'hFFFFFFFE);
        chk("mtlo_busy", 64'(busy), 64'h0);
        op = 3'd4; a = 32'hCAFEF00D; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi", {hi, lo}, 64'hCAFEF00D_00000001);
        op = 3'd6; a = 32'h5555AAAA; b = 32'h3; start = 1'b1;
        @(negedge clk);
        op = 3'd7;
        @(negedge clk);
        start = 1'b0;
        chk("noop_res", {hi, lo}, 64'hCAFEF00D_00000001);
        chk("noop_busy", 64'(busy), 64'h0);

        // stall for 10 cycles mid-RUN
        op = 3'd0; a = 32'd7; b = 32'hFFFFFFFD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        repeat (9) begin
            @(negedge clk);
            cyc++;
        end
        clk_enable = 1'b0;
        repeat (10) begin
            @(negedge clk);
            cyc++;
        end
        clk_enable = 1'b1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("stall_latency", 64'(cyc), 64'd44);
        chk("stall_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

        // reset mid-RUN aborts
        op = 3'd3; a = 32'hFFFFFFFF; b = 32'h3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_res", {hi, lo}, 64'h0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            pulses += int'(done);
        end
        chk("abort_no_done", 64'(pulses), 64'h0);

        for (int o = 0; o < 4; o++)
            for (int i = 0; i < 6; i++)
                for (int j = 0; j < 6; j++) begin
                    run(3'(o), vals[i], vals[j], cyc);
                    chk("table_latency", 64'(cyc), 64'd34);
                end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
